// File: rtl/stream_mux_rr.sv
// N-channel round-robin packet stream multiplexer with a registered output beat.
// A granted channel keeps the output until its last beat is accepted, so packets never interleave.
module stream_mux_rr #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_last,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_last,
  output logic [SEL_W-1:0]          out_sel,
  input  logic                      out_ready
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Arbiter state kept in one struct so state, owner and pointer can be probed together.
  typedef struct packed {
    state_t           state;
    logic [SEL_W-1:0] grant;
    logic [SEL_W-1:0] ptr;
  } arb_t;

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

  arb_t             arb_q, arb_d;
  logic             sel_valid, sel_last;
  logic [WIDTH-1:0] sel_data;
  logic             accept, xfer;
  logic             any_hi, any_lo;
  logic [SEL_W-1:0] pick_hi, pick_lo, pick;
  logic [SEL_W-1:0] ptr_next;

  // Handshake: a beat moves from channel grant when in_valid[grant] && in_ready[grant];
  // in_ready depends only on state, out_valid and out_ready, never on in_valid.
  always_comb begin
    accept = (arb_q.state == LOCKED) && (!out_valid || out_ready);
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    in_ready  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(arb_q.grant) == i) begin
        sel_valid   = in_valid[i];
        sel_last    = in_last[i];
        sel_data    = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = accept;
      end
    end
  end

  assign xfer = accept && sel_valid;

  // Rotating priority: lowest requester at or above ptr wins, else lowest requester below ptr.
  always_comb begin
    any_hi  = 1'b0;
    any_lo  = 1'b0;
    pick_hi = '0;
    pick_lo = '0;
    for (int j = CHANNELS - 1; j >= 0; j--) begin
      if (in_valid[j]) begin
        if (j >= int'(arb_q.ptr)) begin
          any_hi  = 1'b1;
          pick_hi = SEL_W'(j);
        end else begin
          any_lo  = 1'b1;
          pick_lo = SEL_W'(j);
        end
      end
    end
    pick = any_hi ? pick_hi : pick_lo;
  end

  assign ptr_next = (arb_q.grant == LAST_CH) ? '0 : arb_q.grant + SEL_W'(1);

  always_comb begin
    arb_d = arb_q;
    case (arb_q.state)
      IDLE: begin
        if (any_hi || any_lo) begin
          arb_d.state = LOCKED;
          arb_d.grant = pick;
        end
      end
      LOCKED: begin
        if (xfer && sel_last) begin
          arb_d.state = IDLE;
          arb_d.ptr   = ptr_next;
        end
      end
      default: arb_d.state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      arb_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else begin
      arb_q <= arb_d;
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_last  <= sel_last;
        out_sel   <= arb_q.grant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a 4-channel instance driven from a vector table
// plus hand sequences, and a 3-channel instance checked through an expected-beat queue.
module tb_stream_mux_rr;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int SW = 2;
  localparam int N3 = 3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [N-1:0]    in_valid, in_last, in_ready;
  logic [N*W-1:0]  in_data;
  logic            out_valid, out_last, out_ready;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_sel;

  logic            v3_reset;
  logic [N3-1:0]   v3_in_valid, v3_in_last, v3_in_ready;
  logic [N3*W-1:0] v3_in_data;
  logic            v3_out_valid, v3_out_last, v3_out_ready;
  logic [W-1:0]    v3_out_data;
  logic [1:0]      v3_out_sel;

  stream_mux_rr #(.WIDTH(W), .CHANNELS(N)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_sel(out_sel),
    .out_ready(out_ready)
  );

  stream_mux_rr #(.WIDTH(W), .CHANNELS(N3)) dut3 (
    .clk(clk), .reset(v3_reset),
    .in_valid(v3_in_valid), .in_data(v3_in_data), .in_last(v3_in_last), .in_ready(v3_in_ready),
    .out_valid(v3_out_valid), .out_data(v3_out_data), .out_last(v3_out_last), .out_sel(v3_out_sel),
    .out_ready(v3_out_ready)
  );

  int total  = 0;
  int passed = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // vector table
  typedef struct {
    logic        rst;
    logic [3:0]  inv;
    logic [31:0] data;
    logic [3:0]  last;
    logic        ordy;
    logic        chk;
    logic [3:0]  e_rdy;
    logic        e_v;
    logic [7:0]  e_d;
    logic [1:0]  e_sel;
    logic        e_l;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic [3:0] inv, input logic [31:0] data,
                              input logic [3:0] last, input logic ordy, input logic chk,
                              input logic [3:0] e_rdy, input logic e_v, input logic [7:0] e_d,
                              input logic [1:0] e_sel, input logic e_l);
    vec_t v;
    v.rst = rst; v.inv = inv; v.data = data; v.last = last; v.ordy = ordy; v.chk = chk;
    v.e_rdy = e_rdy; v.e_v = e_v; v.e_d = e_d; v.e_sel = e_sel; v.e_l = e_l;
    vecs.push_back(v);
  endfunction

  function automatic void add_rst();
    add(1'b1, 4'h0, 32'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 8'h0, 2'd0, 1'b0);
  endfunction

  // driver tasks
  task automatic drive(input logic rst, input logic [3:0] inv, input logic [31:0] data,
                       input logic [3:0] last, input logic ordy);
    @(negedge clk);
    reset     = rst;
    in_valid  = inv;
    in_data   = data;
    in_last   = last;
    out_ready = ordy;
    #1;
  endtask

  // scoreboard for the 3-channel instance: {sel, last, data}
  logic [10:0] exp_q[$];

  task automatic drive3(input logic rst, input logic [2:0] inv, input logic [23:0] data,
                        input logic [2:0] last, input logic ordy);
    logic [10:0] e;
    @(negedge clk);
    v3_reset     = rst;
    v3_in_valid  = inv;
    v3_in_data   = data;
    v3_in_last   = last;
    v3_out_ready = ordy;
    #1;
    if (!rst && v3_out_valid && v3_out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL sb3 unexpected beat: got %h, expected none",
                 {v3_out_sel, v3_out_last, v3_out_data});
      end else begin
        e = exp_q.pop_front();
        check("sb3 beat", {21'h0, v3_out_sel, v3_out_last, v3_out_data}, {21'h0, e});
      end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = '0; in_data = '0; in_last = '0; out_ready = 1'b1;
    v3_reset = 1'b1; v3_in_valid = '0; v3_in_data = '0; v3_in_last = '0; v3_out_ready = 1'b1;

    // reset values held for 5 cycles
    add_rst(); add_rst();
    for (int i = 0; i < 5; i++) add(0, 4'h0, 32'h0, 4'h0, 1, 1, 4'b0000, 0, 8'h00, 2'd0, 0);

    // round-robin fairness, all channels offering 1-beat packets 0x10+i
    add(0, 4'hF, 32'h1312_1110, 4'hF, 1, 1, 4'b0000, 0, 8'h00, 2'd0, 0);
    add(0, 4'hF, 32'h1312_1110, 4'hF, 1, 1, 4'b0001, 0, 8'h00, 2'd0, 0);
    add(0, 4'hF, 32'h1312_1110, 4'hF, 1, 1, 4'b0000, 1, 8'h10, 2'd0, 1);
    add(0, 4'hF, 32'h1312_1110, 4'hF, 1, 1, 4'b0010, 0, 8'h10, 2'd0, 1);
    add(0, 4'hF, 32'h1312_1110, 4'hF, 1, 1, 4'b0000, 1, 8'h11, 2'd1, 1);
    add(0, 4'hF, 32'h1312_1110, 4'hF, 1, 1, 4'b0100, 0, 8'h11, 2'd1, 1);
    add(0, 4'hF, 32'h1312_1110, 4'hF, 1, 1, 4'b0000, 1, 8'h12, 2'd2, 1);
    add(0, 4'hF, 32'h1312_1110, 4'hF, 1, 1, 4'b1000, 0, 8'h12, 2'd2, 1);
    add(0, 4'hF, 32'h1312_1110, 4'hF, 1, 1, 4'b0000, 1, 8'h13, 2'd3, 1);
    add(0, 4'hF, 32'h1312_1110, 4'hF, 1, 1, 4'b0001, 0, 8'h13, 2'd3, 1);
    add(0, 4'hF, 32'h1312_1110, 4'hF, 1, 1, 4'b0000, 1, 8'h10, 2'd0, 1);
    add(0, 4'hF, 32'h1312_1110, 4'hF, 1, 1, 4'b0010, 0, 8'h10, 2'd0, 1);
    add(0, 4'hF, 32'h1312_1110, 4'hF, 1, 1, 4'b0000, 1, 8'h11, 2'd1, 1);
    add_rst();

    // packet lock: channel 2 sends A0..A2 while channel 0 keeps requesting
    add(0, 4'b0100, 32'h00A0_0000, 4'b0000, 1, 1, 4'b0000, 0, 8'h00, 2'd0, 0);
    add(0, 4'b0101, 32'h00A0_0005, 4'b0001, 1, 1, 4'b0100, 0, 8'h00, 2'd0, 0);
    add(0, 4'b0101, 32'h00A1_0005, 4'b0001, 1, 1, 4'b0100, 1, 8'hA0, 2'd2, 0);
    add(0, 4'b0101, 32'h00A2_0005, 4'b0101, 1, 1, 4'b0100, 1, 8'hA1, 2'd2, 0);
    add(0, 4'b0001, 32'h0000_0005, 4'b0001, 1, 1, 4'b0000, 1, 8'hA2, 2'd2, 1);
    add(0, 4'b0001, 32'h0000_0005, 4'b0001, 1, 1, 4'b0001, 0, 8'hA2, 2'd2, 1);
    add(0, 4'b0000, 32'h0000_0000, 4'b0000, 1, 1, 4'b0000, 1, 8'h05, 2'd0, 1);
    add_rst();

    // backpressure: out_ready low 4 cycles inside a 4-beat channel-1 packet
    add(0, 4'b0010, 32'h0000_B000, 4'b0000, 1, 1, 4'b0000, 0, 8'h00, 2'd0, 0);
    add(0, 4'b0010, 32'h0000_B000, 4'b0000, 1, 1, 4'b0010, 0, 8'h00, 2'd0, 0);
    for (int i = 0; i < 4; i++)
      add(0, 4'b0010, 32'h0000_B100, 4'b0000, 0, 1, 4'b0000, 1, 8'hB0, 2'd1, 0);
    add(0, 4'b0010, 32'h0000_B100, 4'b0000, 1, 1, 4'b0010, 1, 8'hB0, 2'd1, 0);
    add(0, 4'b0010, 32'h0000_B200, 4'b0000, 1, 1, 4'b0010, 1, 8'hB1, 2'd1, 0);
    add(0, 4'b0010, 32'h0000_B300, 4'b0010, 1, 1, 4'b0010, 1, 8'hB2, 2'd1, 0);
    add(0, 4'b0000, 32'h0000_0000, 4'b0000, 1, 1, 4'b0000, 1, 8'hB3, 2'd1, 1);
    add(0, 4'b0000, 32'h0000_0000, 4'b0000, 1, 1, 4'b0000, 0, 8'hB3, 2'd1, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].inv, vecs[i].data, vecs[i].last, vecs[i].ordy);
      if (vecs[i].chk) begin
        check($sformatf("v%0d in_ready", i),  {28'h0, in_ready},  {28'h0, vecs[i].e_rdy});
        check($sformatf("v%0d out_valid", i), {31'h0, out_valid}, {31'h0, vecs[i].e_v});
        check($sformatf("v%0d out_data", i),  {24'h0, out_data},  {24'h0, vecs[i].e_d});
        check($sformatf("v%0d out_sel", i),   {30'h0, out_sel},   {30'h0, vecs[i].e_sel});
        check($sformatf("v%0d out_last", i),  {31'h0, out_last},  {31'h0, vecs[i].e_l});
      end
    end

    // reset mid-packet: channel 1 sends 4 beats, channel 3 requests, reset after beat 2
    drive(1, 4'b0000, 32'h0, 4'b0000, 1);
    drive(0, 4'b0010, 32'h0000_C000, 4'b0000, 1);
    check("mid idle in_ready", {28'h0, in_ready}, 32'h0);
    drive(0, 4'b1010, 32'h3300_C000, 4'b1000, 1);
    check("mid grant1 in_ready", {28'h0, in_ready}, 32'h2);
    drive(0, 4'b1010, 32'h3300_C100, 4'b1000, 1);
    check("mid beat1 data", {24'h0, out_data}, 32'hC0);
    check("mid beat1 sel", {30'h0, out_sel}, 32'h1);
    drive(1, 4'b1010, 32'h3300_C200, 4'b1000, 1);
    check("mid beat2 data", {24'h0, out_data}, 32'hC1);
    drive(0, 4'b1010, 32'h3300_C000, 4'b1000, 1);
    check("mid post-reset out_valid", {31'h0, out_valid}, 32'h0);
    check("mid post-reset out_data", {24'h0, out_data}, 32'h0);
    check("mid post-reset in_ready", {28'h0, in_ready}, 32'h0);
    drive(0, 4'b1010, 32'h3300_C000, 4'b1000, 1);
    check("mid regrant ch1 in_ready", {28'h0, in_ready}, 32'h2);
    drive(0, 4'b1010, 32'h3300_C100, 4'b1000, 1);
    check("mid restart out_valid", {31'h0, out_valid}, 32'h1);
    check("mid restart out_data", {24'h0, out_data}, 32'hC0);
    check("mid restart out_sel", {30'h0, out_sel}, 32'h1);
    drive(1, 4'b0000, 32'h0, 4'b0000, 1);

    // non-power-of-two wrap on the 3-channel instance
    exp_q.push_back({2'd2, 1'b0, 8'h21});
    exp_q.push_back({2'd2, 1'b1, 8'h22});
    exp_q.push_back({2'd0, 1'b1, 8'h07});
    drive3(1, 3'b000, 24'h0, 3'b000, 1);
    drive3(0, 3'b100, 24'h21_0000, 3'b000, 1);
    check("w3 idle in_ready", {29'h0, v3_in_ready}, 32'h0);
    drive3(0, 3'b100, 24'h21_0000, 3'b000, 1);
    check("w3 grant2 in_ready", {29'h0, v3_in_ready}, 32'h4);
    drive3(0, 3'b100, 24'h22_0000, 3'b100, 1);
    check("w3 beat2 in_ready", {29'h0, v3_in_ready}, 32'h4);
    drive3(0, 3'b001, 24'h00_0007, 3'b001, 1);
    check("w3 after last in_ready", {29'h0, v3_in_ready}, 32'h0);
    drive3(0, 3'b001, 24'h00_0007, 3'b001, 1);
    check("w3 grant0 in_ready", {29'h0, v3_in_ready}, 32'h1);
    drive3(0, 3'b000, 24'h0, 3'b000, 1);
    drive3(0, 3'b000, 24'h0, 3'b000, 1);
    check("w3 scoreboard drained", exp_q.size(), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel, W-bit packet stream multiplexer with a registered output. It generalises the 2:1 and 4:1 single-bit gate-level muxes from fixed select lines to internal round-robin arbitration. Each input is a valid/ready/last packet stream. Once a channel is granted, the grant is held until that channel's last beat is accepted, so packets are never interleaved. It sits between several packet producers and one shared consumer port in the circuit datapath.

## Interface
- `WIDTH`, default 8: data bits per beat, ≥1.
- `CHANNELS`, default 4: number of input streams, ≥1; need not be a power of two.
- `SEL_W`, default `max(1, clog2(CHANNELS))`: width of the channel index.
- `clk`: input, 1 bit. Single clock; all state changes on the rising edge.
- `reset`: input, 1 bit. Synchronous, active-high.
- `in_valid`: input, `CHANNELS` bits. Bit i means channel i presents a beat.
- `in_data`: input, `CHANNELS*WIDTH` bits. Channel i occupies bits `[i*WIDTH +: WIDTH]`.
- `in_last`: input, `CHANNELS` bits. Bit i marks channel i's final beat of a packet.
- `in_ready`: output, `CHANNELS` bits. Bit i means channel i's beat is accepted this cycle.
- `out_valid`: output, 1 bit. Output register holds a beat.
- `out_data`: output, `WIDTH` bits. Registered beat data.
- `out_last`: output, 1 bit. Registered last flag.
- `out_sel`: output, `SEL_W` bits. Index of the channel that produced the current output beat.
- `out_ready`: input, 1 bit. Consumer accepts the output beat.

## Operation
- State machine has two states:
  - IDLE: no channel granted.
  - LOCKED: `grant` is the owning channel.
- Round-robin pointer `ptr` (`SEL_W` bits) names the highest-priority channel.
- IDLE behaviour:
  - `in_ready` is all zero; no beat transfers in this state.
  - If any `in_valid` bit is set, grant the first set bit searching `ptr`, `ptr+1`, …, `CHANNELS-1`, 0, …, `ptr-1`, then go to LOCKED.
  - If no bit is set, stay in IDLE.
- LOCKED behaviour:
  - `in_ready[grant] = !out_valid || out_ready`; all other `in_ready` bits are 0.
  - `in_ready` is combinational from state and `out_valid`/`out_ready` only; it never depends on `in_valid`.
- Transfer occurs when `in_valid[grant] && in_ready[grant]`. On a transfer:
  - `out_data <= in_data[grant]`, `out_last <= in_last[grant]`, `out_sel <= grant`, `out_valid <= 1`.
- If the transferred beat has `in_last=1`:
  - Go to IDLE.
  - `ptr <= grant+1`, wrapping from `CHANNELS-1` to 0. Wrap is by compare, not by bit truncation, so non-power-of-two `CHANNELS` works.
- Without a transfer: if `out_valid && out_ready`, then `out_valid <= 0`. Data, last and sel registers hold their values.
- Output stability: while `out_valid && !out_ready`, `out_data`, `out_last` and `out_sel` must not change.
- If the granted channel drops `in_valid` mid-packet, the block stays LOCKED on it indefinitely. Other channels' requests are ignored until its last beat transfers.
- Requests from ungranted channels may change freely; they are sampled only in IDLE.
- `CHANNELS=1`: pointer stays 0 and the grant is always 0.

## Timing
- Reset: state IDLE, `ptr=0`, `out_valid=0`, `out_data=0`, `out_last=0`, `out_sel=0`, `in_ready=0`.
- A reset asserted mid-packet aborts the packet:
  - The output register is cleared.
  - The partially sent packet is not completed.
  - The next arbitration starts from channel 0.
- Arbitration latency: request seen in IDLE at edge t gives `in_ready` high from cycle t+1. The first beat appears on `out_valid` at cycle t+2.
- Steady-state throughput is 1 beat/cycle while `out_ready=1`. Output latency is 1 cycle, input beat to `out_valid`.
- Packet-to-packet gap is exactly 1 idle arbitration cycle. Single-beat packets therefore sustain at most 1 beat per 2 cycles.
- Backpressure: `out_ready=0` with `out_valid=1` forces `in_ready=0` the same cycle. A simultaneous `out_ready=1` and input transfer replaces the output beat with no bubble.

## Test plan
- **Reset values:** after reset with all inputs 0, `in_ready=0000`, `out_valid=0`, `out_data=0`, `out_sel=0`; these hold for 5 cycles.
- **Round-robin fairness:**
  - Stimulus: `CHANNELS=4`, `WIDTH=8`, all four channels continuously offering 1-beat packets carrying data `0x10+i`.
  - Required: `out_sel` sequence 0,1,2,3,0,1; each beat is followed by one idle arbitration cycle.
- **Packet lock:**
  - Stimulus: channel 2 sends a 3-beat packet `0xA0,0xA1,0xA2` with last on the third beat; channel 0 requests throughout.
  - Required: output is `0xA0,0xA1,0xA2` with `out_sel=2`, then channel 0 is granted (ptr=3, wrap finds 0).
- **Backpressure:**
  - Stimulus: `out_ready=0` for 4 cycles mid-packet.
  - Required: `out_data` is held constant, `in_ready[grant]=0`, and no beat is lost or duplicated once `out_ready` returns to 1.
- **Non-power-of-two wrap:**
  - Stimulus: `CHANNELS=3`, only channel 2 sends a packet, then only channel 0.
  - Required: after channel 2's last beat, ptr=0 and channel 0 is granted on the next IDLE cycle.
- **Reset mid-packet:**
  - Stimulus: `reset` pulsed after beat 2 of a 4-beat channel-1 packet, while channel 3 is also requesting.
  - Required: `out_valid=0` on the next cycle, then channel 1 is granted first (ptr=0 searches 0,1,…).
